// File: rtl/cpu_pkg.sv
// Shared definitions for the branch-condition path: condition codes, C2 field width, FSM states.
// BRANCH_CMP_EN adds the two-operand compare codes and the CAPB state.
package cpu_pkg;

  localparam int unsigned C2_WIDTH = 4;

  localparam logic [C2_WIDTH-1:0] COND_BRZR   = 4'd0;
  localparam logic [C2_WIDTH-1:0] COND_BRNZ   = 4'd1;
  localparam logic [C2_WIDTH-1:0] COND_BRPL   = 4'd2;
  localparam logic [C2_WIDTH-1:0] COND_BRMI   = 4'd3;
  localparam logic [C2_WIDTH-1:0] COND_BRGT   = 4'd4;
  localparam logic [C2_WIDTH-1:0] COND_BRLE   = 4'd5;
  localparam logic [C2_WIDTH-1:0] COND_ALWAYS = 4'd6;
  localparam logic [C2_WIDTH-1:0] COND_NEVER  = 4'd7;

  localparam logic [C2_WIDTH-1:0] COND_CMP_EQ = 4'd8;
  localparam logic [C2_WIDTH-1:0] COND_CMP_NE = 4'd9;
  localparam logic [C2_WIDTH-1:0] COND_CMP_LT = 4'd10;
  localparam logic [C2_WIDTH-1:0] COND_CMP_GE = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
`ifdef BRANCH_CMP_EN
    ST_CAPB = 2'd2,
`endif
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: code + operand(s) -> {result, reserved-code error}.
// BRANCH_CMP_EN adds operand B and codes 8-11 as signed/equality compares.
module cond_eval
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [C2_WIDTH-1:0]   code,
  input  logic [DATA_WIDTH-1:0] op_a,
`ifdef BRANCH_CMP_EN
  input  logic [DATA_WIDTH-1:0] op_b,
`endif
  output logic                  result,
  output logic                  err
);

  logic zero;
  logic neg;

  assign zero = (op_a == '0);
  assign neg  = op_a[DATA_WIDTH-1];

  always_comb begin
    result = 1'b0;
    err    = 1'b0;
    case (code)
      COND_BRZR:   result = zero;
      COND_BRNZ:   result = !zero;
      COND_BRPL:   result = !neg;
      COND_BRMI:   result = neg;
      COND_BRGT:   result = !zero && !neg;
      COND_BRLE:   result = zero || neg;
      COND_ALWAYS: result = 1'b1;
      COND_NEVER:  result = 1'b0;
`ifdef BRANCH_CMP_EN
      COND_CMP_EQ: result = (op_a == op_b);
      COND_CMP_NE: result = (op_a != op_b);
      COND_CMP_LT: result = ($signed(op_a) <  $signed(op_b));
      COND_CMP_GE: result = ($signed(op_a) >= $signed(op_b));
`endif
      default:     err = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Registered branch-condition unit: captures IR C2 field and bus on con_in, evaluates next cycle, holds branch.
// BRANCH_CMP_EN inserts a CAPB state that waits for cmp_in to capture operand B for codes 8-11.
module branch_cond_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IR_WIDTH   = 32,
  parameter int unsigned C2_LSB     = 19
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  con_in,
  input  logic [IR_WIDTH-1:0]   ir,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  cmp_in,
  output logic                  branch,
  output logic                  branch_valid,
  output logic                  busy,
  output logic                  cond_err
);

  state_t state;
  state_t state_next;

  logic [C2_WIDTH-1:0]   code_in;
  logic [C2_WIDTH-1:0]   code_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic                  capture_a;
  logic                  finish;
  logic                  eval_result;
  logic                  eval_err;

  // Only the C2 field of ir is consumed; cmp_in matters only with the compare extension.
  logic unused_inputs;
  assign unused_inputs = ^{ir, cmp_in};

  assign code_in = ir[C2_LSB +: C2_WIDTH];

`ifdef BRANCH_CMP_EN
  logic [DATA_WIDTH-1:0] op_b_q;
  logic                  capture_b;
  logic                  to_capb;
  assign to_capb = (code_in[3:2] == 2'b10);
`endif

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture_a  = 1'b0;
    finish     = 1'b0;
`ifdef BRANCH_CMP_EN
    capture_b  = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (con_in) begin
          capture_a  = 1'b1;
          state_next = ST_EVAL;
`ifdef BRANCH_CMP_EN
          if (to_capb) state_next = ST_CAPB;
`endif
        end
      end
`ifdef BRANCH_CMP_EN
      ST_CAPB: begin
        if (cmp_in) begin
          capture_b  = 1'b1;
          state_next = ST_EVAL;
        end
      end
`endif
      ST_EVAL: begin
        finish     = 1'b1;
        state_next = ST_HOLD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE) && (state != ST_HOLD);

  always_ff @(posedge clk) begin
    if (clr) begin
      code_q       <= '0;
      op_a_q       <= '0;
      branch       <= 1'b0;
      branch_valid <= 1'b0;
      cond_err     <= 1'b0;
    end else begin
      if (capture_a) begin
        code_q <= code_in;
        op_a_q <= bus_in;
      end
      branch_valid <= finish;
      if (finish) begin
        branch   <= eval_result;
        cond_err <= eval_err;
      end
    end
  end

`ifdef BRANCH_CMP_EN
  always_ff @(posedge clk) begin
    if (clr)            op_b_q <= '0;
    else if (capture_b) op_b_q <= bus_in;
  end
`endif

  cond_eval #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cond_eval (
    .code   (code_q),
    .op_a   (op_a_q),
`ifdef BRANCH_CMP_EN
    .op_b   (op_b_q),
`endif
    .result (eval_result),
    .err    (eval_err)
  );

endmodule
